// File: rtl/ftsd_scan.sv
// ftsd_scan: time-multiplexed 14-segment (+dp) display scanner.
// Ports: clk, rst (sync, active-high), enable, value[4*DIGITS], dp_en, blank,
//        lz_en in; segment[14:0] (active-low, [0]=dp), digit_sel (active-low),
//        frame_start out.
module ftsd_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_en,
    input  logic [DIGITS-1:0]   blank,
    input  logic                lz_en,
    output logic [14:0]         segment,
    output logic [DIGITS-1:0]   digit_sel,
    output logic                frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("ftsd_scan: DIGITS must be 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("ftsd_scan: SCAN_DIV must be >= 2");
    end

    function automatic logic [14:0] decode(input logic [3:0] c);
        logic [14:0] s;
        case (c)
            4'h0:    s = 15'h01FF;
            4'h1:    s = 15'h4FFF;
            4'h2:    s = 15'h127F;
            4'h3:    s = 15'h067F;
            4'h4:    s = 15'h4C7F;
            4'h5:    s = 15'h247F;
            4'h6:    s = 15'h207F;
            4'h7:    s = 15'h0FFF;
            4'h8:    s = 15'h007F;
            4'h9:    s = 15'h047F;
            4'hA:    s = 15'h087F;
            4'hB:    s = 15'h075B;
            4'hC:    s = 15'h31FF;
            4'hD:    s = 15'h07DB;
            4'hE:    s = 15'h307F;
            default: s = 15'h387F;
        endcase
        return s;
    endfunction

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic                tick;
    logic                tick_d;
    logic [4*DIGITS-1:0] snap_val;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_blank;
    logic                snap_lz;
    logic [3:0]          code;
    logic                suppress;
    logic [14:0]         seg_next;
    logic [DIGITS-1:0]   sel_next;

    assign tick = (presc == P_LAST);

    // Digit idx is a leading zero when it and every higher code are zero.
    always_comb begin
        code     = snap_val[4*int'(idx) +: 4];
        suppress = snap_lz && (idx != '0)
                   && ((snap_val >> {idx, 2'b00}) == '0);
        seg_next = decode(code);
        if (suppress) begin
            seg_next[14:1] = '1;
        end
        seg_next[0] = ~snap_dp[idx];
        if (snap_blank[idx]) begin
            seg_next = 15'h7FFF;
        end
        sel_next      = '1;
        sel_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            idx         <= I_LAST;
            tick_d      <= 1'b0;
            snap_val    <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            segment     <= 15'h7FFF;
            digit_sel   <= '1;
            frame_start <= 1'b0;
        end else if (!enable) begin
            presc       <= '0;
            idx         <= I_LAST;
            tick_d      <= 1'b0;
            segment     <= 15'h7FFF;
            digit_sel   <= '1;
            frame_start <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            tick_d <= tick;
            if (tick) begin
                if (idx == I_LAST) begin
                    idx        <= '0;
                    snap_val   <= value;
                    snap_dp    <= dp_en;
                    snap_blank <= blank;
                    snap_lz    <= lz_en;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            // Outputs follow the tick by one cycle so they read the new idx.
            frame_start <= 1'b0;
            if (tick_d) begin
                segment     <= seg_next;
                digit_sel   <= sel_next;
                frame_start <= (idx == '0);
            end
        end
    end

endmodule

// File: tb/tb_ftsd_scan.sv
// tb_ftsd_scan: self-checking bench for ftsd_scan (DIGITS=4, SCAN_DIV=4).
// Reference: expected display derived from cycle count since restart.
module tb_ftsd_scan;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int HN = 4096;

    localparam logic [14:0] TBL [16] = '{
        15'h01FF, 15'h4FFF, 15'h127F, 15'h067F,
        15'h4C7F, 15'h247F, 15'h207F, 15'h0FFF,
        15'h007F, 15'h047F, 15'h087F, 15'h075B,
        15'h31FF, 15'h07DB, 15'h307F, 15'h387F
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_en = '0;
    logic [3:0]  blank = '0;
    logic        lz_en = 1'b0;
    logic [14:0] segment;
    logic [3:0]  digit_sel;
    logic        frame_start;

    always #5 clk = ~clk;

    ftsd_scan #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value),
        .dp_en(dp_en), .blank(blank), .lz_en(lz_en),
        .segment(segment), .digit_sel(digit_sel),
        .frame_start(frame_start)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int rstart = 0;

    logic [15:0] h_val [HN];
    logic [3:0]  h_dp  [HN];
    logic [3:0]  h_bl  [HN];
    logic        h_lz  [HN];
    logic        h_rst [HN];
    logic        h_en  [HN];

    // Record the inputs seen at the coming edge, then advance one cycle.
    task automatic clk_step();
        h_val[cyc] = value;
        h_dp[cyc]  = dp_en;
        h_bl[cyc]  = blank;
        h_lz[cyc]  = lz_en;
        h_rst[cyc] = rst;
        h_en[cyc]  = enable;
        @(posedge clk);
        #1;
        cyc++;
        if (h_rst[cyc-1] || !h_en[cyc-1]) rstart = cyc;
    endtask

    function automatic logic [14:0] ref_seg(logic [15:0] v, logic [3:0] dp,
                                            logic [3:0] bl, logic lz, int d);
        logic [14:0] s;
        logic [3:0]  c;
        if (bl[d]) return 15'h7FFF;
        c = 4'(v >> (4*d));
        s = TBL[c];
        if (lz && d >= 1 && (v >> (4*d)) == 16'd0) s = 15'h7FFF;
        if (dp[d]) s[0] = 1'b0;
        return s;
    endfunction

    // Slot k after the first presentation shows digit (k/SD)%D; frame f
    // uses the inputs seen at its reload edge.
    function automatic logic [19:0] expect_now();
        int rel, k, slot, d, f, sc;
        logic [3:0] sel;
        rel = cyc - rstart;
        if (rel < SD + 1) return {15'h7FFF, 4'hF, 1'b0};
        k    = rel - SD - 1;
        slot = k / SD;
        d    = slot % D;
        f    = slot / D;
        sc   = rstart + SD - 1 + f * SD * D;
        sel  = 4'hF;
        sel[d] = 1'b0;
        return {ref_seg(h_val[sc], h_dp[sc], h_bl[sc], h_lz[sc], d),
                sel, (k % (SD * D)) == 0};
    endfunction

    task automatic do_restart();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] got;
        for (int i = 0; i < 4; i++) begin
            got = {segment, digit_sel, frame_start};
            n_chk++;
            if (got !== {15'h7FFF, 4'hF, 1'b0})
                $display("FAIL reset i=%0d got %h want %h", i, got,
                         {15'h7FFF, 4'hF, 1'b0});
            else n_pass++;
            enable = 1'b1;
            value = 16'($urandom);
            clk_step();
        end
    endtask

    // Runs n cycles, comparing against the model every cycle and against
    // fixed display words at the listed cycles after restart.
    task automatic run_pattern(string nm, logic [15:0] v, logic [3:0] dp,
                               logic [3:0] bl, logic lz, int n,
                               int rs[4], logic [19:0] ev[4]);
        logic [19:0] got;
        logic [19:0] ex;
        do_restart();
        value = v; dp_en = dp; blank = bl; lz_en = lz;
        for (int i = 0; i < n; i++) begin
            clk_step();
            got = {segment, digit_sel, frame_start};
            ex  = expect_now();
            n_chk++;
            if (got !== ex)
                $display("FAIL %s_model cyc=%0d got %h want %h",
                         nm, cyc, got, ex);
            else n_pass++;
            for (int j = 0; j < 4; j++) begin
                if (cyc - rstart == rs[j]) begin
                    n_chk++;
                    if (got !== ev[j])
                        $display("FAIL %s_word rel=%0d got %h want %h",
                                 nm, rs[j], got, ev[j]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_basic();
        run_pattern("basic", 16'h1234, 4'b0, 4'b0, 1'b0, 40,
            '{5, 9, 13, 21},
            '{{15'h4C7F, 4'hE, 1'b1}, {15'h067F, 4'hD, 1'b0},
              {15'h127F, 4'hB, 1'b0}, {15'h4C7F, 4'hE, 1'b1}});
        run_pattern("digit3", 16'h1234, 4'b0, 4'b0, 1'b0, 20,
            '{17, 18, 20, 16},
            '{{15'h4FFF, 4'h7, 1'b0}, {15'h4FFF, 4'h7, 1'b0},
              {15'h4FFF, 4'h7, 1'b0}, {15'h127F, 4'hB, 1'b0}});
    endtask

    task automatic test_lz_dp();
        run_pattern("lz_dp", 16'h0050, 4'b0010, 4'b0, 1'b1, 24,
            '{5, 9, 13, 17},
            '{{15'h01FF, 4'hE, 1'b1}, {15'h247E, 4'hD, 1'b0},
              {15'h7FFF, 4'hB, 1'b0}, {15'h7FFF, 4'h7, 1'b0}});
    endtask

    task automatic test_all_zero();
        run_pattern("zero", 16'h0000, 4'b0, 4'b0, 1'b1, 24,
            '{5, 9, 13, 17},
            '{{15'h01FF, 4'hE, 1'b1}, {15'h7FFF, 4'hD, 1'b0},
              {15'h7FFF, 4'hB, 1'b0}, {15'h7FFF, 4'h7, 1'b0}});
    endtask

    task automatic test_blank();
        run_pattern("blank", 16'h1234, 4'b0011, 4'b0001, 1'b0, 24,
            '{5, 9, 4, 13},
            '{{15'h7FFF, 4'hE, 1'b1}, {15'h067E, 4'hD, 1'b0},
              {15'h7FFF, 4'hF, 1'b0}, {15'h127F, 4'hB, 1'b0}});
    endtask

    task automatic test_snapshot();
        logic [19:0] got;
        logic [19:0] ex;
        do_restart();
        value = 16'h1234; dp_en = '0; blank = '0; lz_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            got = {segment, digit_sel, frame_start};
            ex  = expect_now();
            n_chk++;
            if (got !== ex)
                $display("FAIL snap_model cyc=%0d got %h want %h", cyc, got, ex);
            else n_pass++;
            if (cyc - rstart == 14) value = 16'hABCD;
            if (cyc - rstart == 17) begin
                n_chk++;
                if (got !== {15'h4FFF, 4'h7, 1'b0})
                    $display("FAIL snap_old got %h want %h", got,
                             {15'h4FFF, 4'h7, 1'b0});
                else n_pass++;
            end
            if (cyc - rstart == 21) begin
                n_chk++;
                if (got !== {15'h07DB, 4'hE, 1'b1})
                    $display("FAIL snap_new got %h want %h", got,
                             {15'h07DB, 4'hE, 1'b1});
                else n_pass++;
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [19:0] got;
        logic [19:0] ex;
        int t_drop;
        int t_en;
        t_drop = -100;
        t_en = -100;
        do_restart();
        value = 16'h1234; dp_en = '0; blank = '0; lz_en = 1'b0;
        for (int i = 0; i < 34; i++) begin
            clk_step();
            got = {segment, digit_sel, frame_start};
            ex  = expect_now();
            n_chk++;
            if (got !== ex)
                $display("FAIL en_model cyc=%0d got %h want %h", cyc, got, ex);
            else n_pass++;
            if (cyc == t_drop + 1) begin
                n_chk++;
                if (got !== {15'h7FFF, 4'hF, 1'b0})
                    $display("FAIL en_off got %h want %h", got,
                             {15'h7FFF, 4'hF, 1'b0});
                else n_pass++;
            end
            if (cyc == t_en + 5) begin
                n_chk++;
                if (got !== {15'h4C7F, 4'hE, 1'b1})
                    $display("FAIL en_restart got %h want %h", got,
                             {15'h4C7F, 4'hE, 1'b1});
                else n_pass++;
            end
            if (i == 10) begin enable = 1'b0; t_drop = cyc; end
            if (i == 13) begin enable = 1'b1; t_en = cyc; end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] got;
        logic [19:0] ex;
        int t_rst;
        t_rst = -100;
        do_restart();
        value = 16'h1234; dp_en = '0; blank = '0; lz_en = 1'b0;
        for (int i = 0; i < 34; i++) begin
            clk_step();
            got = {segment, digit_sel, frame_start};
            ex  = expect_now();
            n_chk++;
            if (got !== ex)
                $display("FAIL rmid_model cyc=%0d got %h want %h", cyc, got, ex);
            else n_pass++;
            if (cyc == t_rst + 1) begin
                n_chk++;
                if (got !== {15'h7FFF, 4'hF, 1'b0})
                    $display("FAIL rmid_blank got %h want %h", got,
                             {15'h7FFF, 4'hF, 1'b0});
                else n_pass++;
                rst = 1'b0;
                value = 16'h5678;
            end
            if (cyc == t_rst + 6) begin
                n_chk++;
                if (got !== {15'h007F, 4'hE, 1'b1})
                    $display("FAIL rmid_reload got %h want %h", got,
                             {15'h007F, 4'hE, 1'b1});
                else n_pass++;
            end
            if (i == 10) begin rst = 1'b1; t_rst = cyc; end
        end
    endtask

    task automatic test_random();
        logic [19:0] got;
        logic [19:0] ex;
        do_restart();
        for (int i = 0; i < 700; i++) begin
            value  = 16'($urandom);
            dp_en  = 4'($urandom);
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            lz_en  = 1'($urandom);
            if ($urandom_range(0, 1) == 0) value[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) value[7:4] = 4'h0;
            enable = ($urandom_range(0, 39) != 0);
            rst    = ($urandom_range(0, 59) == 0);
            clk_step();
            got = {segment, digit_sel, frame_start};
            ex  = expect_now();
            n_chk++;
            if (got !== ex)
                $display("FAIL rand_model cyc=%0d got %h want %h", cyc, got, ex);
            else n_pass++;
        end
        rst = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        rstart = 0;
        test_reset();
        test_basic();
        test_lz_dp();
        test_all_zero();
        test_blank();
        test_snapshot();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
